nt_neurotransmitter_bank: RTL and testbench

Parametrised, multi-channel successor to the single neurotransmitter resource counter. It holds CH independent saturating W-bit levels, such as norepinephrine, dopamine and serotonin. Each channel takes the same inc/dec/fast/setval requests from its regulator. A shared prescaler drives automatic reuptake (decay) of idle channels toward a programmable baseline. The block exports full values, downscaled levels and saturation flags to the emotional-state logic.

---
 rtl/nt_neurotransmitter_bank_if.sv | 28 ++
 rtl/nt_neurotransmitter_bank.sv | 80 ++++++++
 tb/tb_nt_neurotransmitter_bank.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/nt_neurotransmitter_bank_if.sv
// Request/status bundle between the channel regulators, the transmitter bank
// and the emotional-state logic.
interface nt_neurotransmitter_bank_if #(
    parameter int CH       = 4,
    parameter int W        = 6,
    parameter int OUT_BITS = 2
);
    logic [CH-1:0]          inc;
    logic [CH-1:0]          dec;
    logic [CH-1:0]          fast;
    logic [CH-1:0]          setval;
    logic                   decay_en;
    logic [CH*W-1:0]        value;
    logic [CH*OUT_BITS-1:0] level;
    logic [CH-1:0]          sat_hi;
    logic [CH-1:0]          sat_lo;
    logic                   decay_tick;

    modport master (
        output inc, dec, fast, setval, decay_en,
        input  value, level, sat_hi, sat_lo, decay_tick
    );

    modport slave (
        input  inc, dec, fast, setval, decay_en,
        output value, level, sat_hi, sat_lo, decay_tick
    );
endinterface

// File: rtl/nt_neurotransmitter_bank.sv
// Bank of CH saturating neurotransmitter levels with a shared reuptake
// prescaler that pulls idle channels one LSB toward BASELINE per tick.
module nt_neurotransmitter_bank #(
    parameter int CH          = 4,
    parameter int W           = 6,
    parameter int FAST_STEP   = 3,
    parameter int SET_VAL     = 32,
    parameter int DEFAULT_VAL = 0,
    parameter int BASELINE    = 16,
    parameter int DECAY_DIV   = 64,
    parameter int OUT_BITS    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    nt_neurotransmitter_bank_if.slave   bus
);
    localparam int             PW     = $clog2(DECAY_DIV);
    localparam logic [PW-1:0]  LAST   = PW'(DECAY_DIV - 1);
    localparam logic [W:0]     MAX_X  = {1'b0, {W{1'b1}}};
    localparam logic [W:0]     FAST_X = (W+1)'(FAST_STEP);
    localparam logic [W:0]     ONE_X  = (W+1)'(1);
    localparam logic [W-1:0]   SET_V  = W'(SET_VAL);
    localparam logic [W-1:0]   DEF_V  = W'(DEFAULT_VAL);
    localparam logic [W-1:0]   BASE_V = W'(BASELINE);

    logic [PW-1:0] cnt_q;
    logic          tick;

    // Pausing decay_en freezes the phase rather than clearing it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (bus.decay_en)
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end

    assign tick           = bus.decay_en && (cnt_q == LAST);
    assign bus.decay_tick = tick;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [W-1:0] val_q;
        logic [W-1:0] val_d;
        logic [W:0]   step;
        logic [W:0]   sum;
        logic [W:0]   diff;

        // One extra bit: sum overflow shows as > MAX_X, underflow sets diff[W].
        always_comb begin
            step  = bus.fast[c] ? FAST_X : ONE_X;
            sum   = {1'b0, val_q} + step;
            diff  = {1'b0, val_q} - step;
            val_d = val_q;
            if (bus.setval[c]) begin
                val_d = SET_V;
            end else if (bus.inc[c] ^ bus.dec[c]) begin
                if (bus.inc[c])
                    val_d = (sum > MAX_X) ? MAX_X[W-1:0] : sum[W-1:0];
                else
                    val_d = diff[W] ? '0 : diff[W-1:0];
            end else if (tick) begin
                if (val_q < BASE_V)
                    val_d = val_q + W'(1);
                else if (val_q > BASE_V)
                    val_d = val_q - W'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                val_q <= DEF_V;
            else
                val_q <= val_d;
        end

        assign bus.value[c*W +: W]               = val_q;
        assign bus.level[c*OUT_BITS +: OUT_BITS] = val_q[W-1 -: OUT_BITS];
        assign bus.sat_hi[c]                     = &val_q;
        assign bus.sat_lo[c]                     = ~|val_q;
    end
endmodule

// File: tb/tb_nt_neurotransmitter_bank.sv
// Directed bench for nt_neurotransmitter_bank with default parameters.
module tb_nt_neurotransmitter_bank;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    nt_neurotransmitter_bank_if #(.CH(4), .W(6), .OUT_BITS(2)) bus ();

    nt_neurotransmitter_bank #(
        .CH(4), .W(6), .FAST_STEP(3), .SET_VAL(32), .DEFAULT_VAL(0),
        .BASELINE(16), .DECAY_DIV(64), .OUT_BITS(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] chv(input int c);
        return bus.value[c*6 +: 6];
    endfunction

    task automatic idle();
        bus.inc    = '0;
        bus.dec    = '0;
        bus.fast   = '0;
        bus.setval = '0;
    endtask

    initial begin
        int e;
        errors       = 0;
        checks       = 0;
        rst          = 1'b0;
        bus.decay_en = 1'b0;
        idle();

        // reset asserted between edges, requests held during reset
        #3 rst = 1'b1;
        bus.inc = 4'b1111;
        #1;
        chk("rst_value", bus.value, 24'd0);
        chk("rst_sat_lo", bus.sat_lo, 4'b1111);
        chk("rst_sat_hi", bus.sat_hi, 4'b0000);
        chk("rst_level", bus.level, 8'd0);
        chk("rst_tick", bus.decay_tick, 1'b0);
        @(negedge clk);
        chk("rst_ignores_inc", bus.value, 24'd0);
        rst = 1'b0;
        idle();

        // saturation upward
        bus.setval = 4'b0001;
        step();
        chk("setval_ch0", chv(0), 32);
        bus.setval = '0;
        bus.inc    = 4'b0001;
        bus.fast   = 4'b0001;
        e = 32;
        for (int i = 1; i <= 12; i++) begin
            step();
            e = (e + 3 > 63) ? 63 : e + 3;
            chk("inc_fast_ch0", chv(0), e);
            if (i == 11) begin
                chk("sat_hi_ch0", bus.sat_hi[0], 1'b1);
                chk("level_ch0", bus.level[1:0], 2'd3);
            end
        end

        // saturation downward without wrap
        bus.inc  = '0;
        bus.fast = '0;
        bus.dec  = 4'b0001;
        repeat (62) step();
        chk("dec_to_1_ch0", chv(0), 1);
        bus.fast = 4'b0001;
        step();
        chk("dec_fast_from_1", chv(0), 0);
        chk("sat_lo_ch0", bus.sat_lo[0], 1'b1);
        step();
        chk("dec_fast_at_0", chv(0), 0);
        idle();

        // priority and conflicts on ch1
        bus.setval = 4'b0010;
        step();
        bus.setval = '0;
        bus.dec    = 4'b0010;
        bus.fast   = 4'b0010;
        repeat (4) step();
        chk("ch1_at_20", chv(1), 20);
        bus.inc = 4'b0010;
        step();
        chk("inc_and_dec_hold", chv(1), 20);
        bus.dec    = '0;
        bus.setval = 4'b0010;
        step();
        chk("setval_over_inc", chv(1), 32);
        chk("others_unaffected", bus.value, {6'd0, 6'd0, 6'd32, 6'd0});
        idle();

        // decay setup: ch1=16, ch2=20, ch3=10
        bus.setval = 4'b1100;
        step();
        bus.setval = '0;
        bus.dec    = 4'b1110;
        bus.fast   = 4'b1110;
        repeat (4) step();
        bus.dec  = 4'b1010;
        bus.fast = 4'b1010;
        step();
        bus.fast = 4'b1000;
        step();
        bus.dec = 4'b1000;
        step();
        bus.fast = '0;
        step();
        idle();
        chk("decay_setup", bus.value, {6'd10, 6'd20, 6'd16, 6'd0});

        bus.decay_en = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            repeat (62) step();
            chk("tick_low_before", bus.decay_tick, 1'b0);
            step();
            chk("tick_high", bus.decay_tick, 1'b1);
            step();
            chk("tick_one_cycle", bus.decay_tick, 1'b0);
            chk("decay_ch2", chv(2), (20 - k < 16) ? 16 : 20 - k);
            chk("decay_ch3", chv(3), (10 + k > 16) ? 16 : 10 + k);
            chk("decay_ch0", chv(0), k);
            chk("baseline_ch1", chv(1), 16);
        end

        // prescaler pause at count 30
        repeat (30) step();
        bus.decay_en = 1'b0;
        repeat (100) step();
        chk("paused_tick", bus.decay_tick, 1'b0);
        chk("paused_frozen", bus.value, {6'd16, 6'd16, 6'd16, 6'd7});
        bus.setval = 4'b0100;
        step();
        bus.setval = '0;
        chk("paused_setval_ch2", chv(2), 32);
        bus.decay_en = 1'b1;
        repeat (32) step();
        chk("resume_tick_low", bus.decay_tick, 1'b0);
        step();
        chk("resume_tick_33", bus.decay_tick, 1'b1);
        bus.inc  = 4'b0001;
        bus.fast = 4'b0001;
        step();
        idle();
        chk("tick_inc_ch0", chv(0), 10);
        chk("tick_decay_ch2", chv(2), 31);
        chk("tick_hold_ch3", chv(3), 16);

        // reset mid-count at prescaler 50
        repeat (50) step();
        #2 rst = 1'b1;
        #1;
        chk("midrst_value", bus.value, 24'd0);
        chk("midrst_tick", bus.decay_tick, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_sat_lo", bus.sat_lo, 4'b1111);
        repeat (13) step();
        chk("midrst_no_stale_tick", bus.decay_tick, 1'b0);
        repeat (49) step();
        chk("midrst_tick_low_62", bus.decay_tick, 1'b0);
        step();
        chk("midrst_tick_63", bus.decay_tick, 1'b1);
        step();
        chk("midrst_decay_up", bus.value, {6'd1, 6'd1, 6'd1, 6'd1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
